lsu_multicycle: RTL and testbench

- Parametrised multicycle load/store unit; successor to the single-cycle LSU path in the core.
- Sits between the IEU and a data memory port that has variable latency (ready handshake).
- Stalls the core while an access is in flight.
- Supports XLEN 32 or 64 and optionally splits misaligned accesses into two aligned memory beats.

---
 rtl/lsu_multicycle_if.sv | 23 ++
 rtl/lsu_multicycle.sv | 180 ++++++++++++++++++
 tb/tb_lsu_multicycle.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_multicycle_if.sv
// Data memory port between the multicycle LSU and a variable-latency memory.
// The master drives one aligned beat per request; the slave completes it with MemReady.
interface lsu_multicycle_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   MemAdr;
    logic [XLEN-1:0]   MemWriteData;
    logic [XLEN-1:0]   MemReadData;
    logic              MemEn;
    logic              WriteEn;
    logic [XLEN/8-1:0] WriteByteEn;
    logic              MemReady;

    modport master (
        output MemAdr, MemWriteData, MemEn, WriteEn, WriteByteEn,
        input  MemReadData, MemReady
    );

    modport slave (
        input  MemAdr, MemWriteData, MemEn, WriteEn, WriteByteEn,
        output MemReadData, MemReady
    );
endinterface

// File: rtl/lsu_multicycle.sv
// Multicycle load/store unit: one or two aligned memory beats per access,
// stalling the core until the access retires in DONE.
module lsu_multicycle #(
    parameter int XLEN          = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      MemRW,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] IEUAdr,
    input  logic [XLEN-1:0] StoreData,
    output logic [XLEN-1:0] LoadResult,
    output logic            Stall,
    output logic            Fault,
    lsu_multicycle_if.master mem
);
    localparam int B  = XLEN / 8;
    localparam int OW = $clog2(B);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   adr_q, adr_d;
    logic [2:0]        f3_q, f3_d;
    logic              st_q, st_d;
    logic              split_q, split_d;
    logic [XLEN-1:0]   sdata_q, sdata_d;
    logic [XLEN-1:0]   buf0_q, buf0_d;
    logic [XLEN-1:0]   buf1_q, buf1_d;
    logic              mem_en_q, mem_en_d;
    logic              wr_en_q, wr_en_d;
    logic [XLEN-1:0]   mem_adr_q, mem_adr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [B-1:0]      wbe_q, wbe_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [OW-1:0]     off_in, off_d;
    logic [3:0]        size_in, size_d;
    logic              req, crossing, fault_c, accept;
    logic [XLEN-1:0]   beat_adr;
    logic [2*XLEN-1:0] wdata2;
    logic [B-1:0]      bmask;
    logic [2*B-1:0]    mask2;
    logic [XLEN-1:0]   sh, ext;
    logic              msb;

    // Request qualification in IDLE: boundary check, fault pulse and stall.
    always_comb begin
        off_in   = IEUAdr[OW-1:0];
        size_in  = 4'd1 << Funct3[1:0];
        req      = (MemRW != 2'b00);
        crossing = (5'(off_in) + 5'(size_in)) > 5'(B);
        fault_c  = req && crossing && !MISALIGNED_EN;
        accept   = (state_q == IDLE) && req && !fault_c;
        Fault    = (state_q == IDLE) && fault_c;
        Stall    = accept || (state_q == BEAT0) || (state_q == BEAT1);
    end

    // Next-state logic; the request is latched on accept so DONE ignores inputs.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        f3_d    = f3_q;
        st_d    = st_q;
        split_d = split_q;
        sdata_d = sdata_q;
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BEAT0;
                    adr_d   = IEUAdr;
                    f3_d    = Funct3;
                    st_d    = (MemRW == 2'b01);
                    split_d = crossing;
                    sdata_d = StoreData;
                    buf0_d  = '0;
                    buf1_d  = '0;
                end
            end
            BEAT0: begin
                if (mem.MemReady) begin
                    buf0_d  = mem.MemReadData;
                    state_d = split_q ? BEAT1 : DONE;
                end
            end
            BEAT1: begin
                if (mem.MemReady) begin
                    buf1_d  = mem.MemReadData;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output values for the next cycle, derived from the next state.
    always_comb begin
        off_d    = adr_d[OW-1:0];
        size_d   = 4'd1 << f3_d[1:0];
        beat_adr = {adr_d[XLEN-1:OW], {OW{1'b0}}}
                 + ((state_d == BEAT1) ? XLEN'(B) : XLEN'(0));
        wdata2   = {{XLEN{1'b0}}, sdata_d} << {off_d, 3'b000};
        bmask    = '0;
        for (int i = 0; i < B; i++) begin
            bmask[i] = (4'(i) < size_d);
        end
        mask2    = {{B{1'b0}}, bmask} << off_d;
        sh       = XLEN'({buf1_d, buf0_d} >> {off_d, 3'b000});
        msb      = 1'b0;
        for (int i = 0; i < B; i++) begin
            if (4'(i + 1) == size_d) msb = sh[8*i+7];
        end
        ext      = '0;
        for (int i = 0; i < B; i++) begin
            if (4'(i) < size_d) ext[8*i +: 8] = sh[8*i +: 8];
            else                ext[8*i +: 8] = {8{msb & ~f3_d[2]}};
        end
        mem_en_d    = (state_d == BEAT0) || (state_d == BEAT1);
        wr_en_d     = mem_en_d && st_d;
        mem_adr_d   = mem_en_d ? beat_adr : '0;
        mem_wdata_d = '0;
        wbe_d       = '0;
        if (wr_en_d) begin
            if (state_d == BEAT1) begin
                mem_wdata_d = wdata2[2*XLEN-1:XLEN];
                wbe_d       = mask2[2*B-1:B];
            end else begin
                mem_wdata_d = wdata2[XLEN-1:0];
                wbe_d       = mask2[B-1:0];
            end
        end
        result_d = (state_d == DONE) ? ext : '0;
    end

    // State, latched request, beat buffers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            adr_q       <= '0;
            f3_q        <= '0;
            st_q        <= 1'b0;
            split_q     <= 1'b0;
            sdata_q     <= '0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            mem_en_q    <= 1'b0;
            wr_en_q     <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            wbe_q       <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            f3_q        <= f3_d;
            st_q        <= st_d;
            split_q     <= split_d;
            sdata_q     <= sdata_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            mem_en_q    <= mem_en_d;
            wr_en_q     <= wr_en_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            wbe_q       <= wbe_d;
            result_q    <= result_d;
        end
    end

    assign mem.MemEn        = mem_en_q;
    assign mem.WriteEn      = wr_en_q;
    assign mem.MemAdr       = mem_adr_q;
    assign mem.MemWriteData = mem_wdata_q;
    assign mem.WriteByteEn  = wbe_q;
    assign LoadResult       = result_q;
endmodule

// File: tb/tb_lsu_multicycle.sv
// Bench for lsu_multicycle: directed beats on XLEN=32/64 instances plus
// randomized loads/stores checked against a byte-addressed reference memory.
module tb_lsu_multicycle;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  rw32, rw64;
    logic [2:0]  f32, f64;
    logic [31:0] a32, sd32, lr32;
    logic [63:0] a64, sd64, lr64;
    logic        st32, ft32, st64, ft64;

    lsu_multicycle_if #(.XLEN(32)) m32();
    lsu_multicycle_if #(.XLEN(64)) m64();

    logic        auto = 1'b0;
    logic        d_ready, rsp_ready = 1'b0, r64;
    logic [31:0] d_data, rsp_data = '0;
    logic [63:0] d64;
    assign m32.MemReady    = auto ? rsp_ready : d_ready;
    assign m32.MemReadData = auto ? rsp_data : d_data;
    assign m64.MemReady    = r64;
    assign m64.MemReadData = d64;

    lsu_multicycle #(.XLEN(32), .MISALIGNED_EN(1'b1)) u32 (
        .clk(clk), .reset(rst), .MemRW(rw32), .Funct3(f32), .IEUAdr(a32),
        .StoreData(sd32), .LoadResult(lr32), .Stall(st32), .Fault(ft32),
        .mem(m32.master));

    lsu_multicycle #(.XLEN(64), .MISALIGNED_EN(1'b0)) u64 (
        .clk(clk), .reset(rst), .MemRW(rw64), .Funct3(f64), .IEUAdr(a64),
        .StoreData(sd64), .LoadResult(lr64), .Stall(st64), .Fault(ft64),
        .mem(m64.master));

    logic [7:0] mem  [256] = '{default: 8'h00};
    logic [7:0] refm [256] = '{default: 8'h00};
    int waits = 0;
    int n_checks = 0;
    int n_err = 0;

    // Random-latency memory responder for the XLEN=32 instance.
    always @(negedge clk) begin
        if (auto) begin
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (m32.MemEn) begin
                for (int b = 0; b < 4; b++)
                    rsp_data[8*b +: 8] = mem[8'(m32.MemAdr[7:0] + 8'(b))];
                if (!rsp_ready) waits++;
                else if (m32.WriteEn)
                    for (int b = 0; b < 4; b++)
                        if (m32.WriteByteEn[b])
                            mem[8'(m32.MemAdr[7:0] + 8'(b))] = m32.MemWriteData[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = '0;
        int sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++) v[8*i +: 8] = refm[8'(a + 32'(i))];
        if (!f3[2] && sz < 4 && v[8*sz-1])
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic do_acc(input logic [1:0] rw, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          output int stalls, output logic [31:0] res,
                          output logic [31:0] adr0, output logic [31:0] adr1);
        bit ok = 0;
        bit seen = 0;
        stalls = 0;
        res = '0;
        adr0 = '0;
        adr1 = '0;
        step();
        rw32 = rw; f32 = f3; a32 = a; sd32 = sd;
        #1;
        for (int c = 0; c < 64; c++) begin
            if (m32.MemEn) begin
                if (!seen) adr0 = m32.MemAdr;
                adr1 = m32.MemAdr;
                seen = 1;
            end
            if (st32) stalls++;
            else begin
                res = lr32;
                ok = 1;
                break;
            end
            step();
        end
        rw32 = 2'b00;
        chk("acc_done", 64'(ok), 64'd1);
    endtask

    task automatic acc64(input string tag, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] data, input logic [63:0] exp);
        step();
        rw64 = 2'b10; f64 = f3; a64 = a; r64 = 1'b1; d64 = data;
        #1;
        chk({tag, "_stall0"}, 64'(st64), 64'd1);
        step();
        chk({tag, "_adr"}, m64.MemAdr, {a[63:3], 3'b000});
        step();
        chk({tag, "_stall_done"}, 64'(st64), 64'd0);
        chk(tag, lr64, exp);
        rw64 = 2'b00;
    endtask

    initial begin
        int stalls, w0, sz;
        logic [31:0] res, adr0, adr1, a, sd, exp;
        logic [2:0] f3;
        logic [1:0] rw;
        logic [2:0] ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bit split;

        rst = 1'b1;
        rw32 = '0; f32 = '0; a32 = '0; sd32 = '0;
        rw64 = '0; f64 = '0; a64 = '0; sd64 = '0;
        d_ready = 1'b0; d_data = '0; r64 = 1'b0; d64 = '0;
        step();
        step();
        chk("rst_memen32", 64'(m32.MemEn), 64'd0);
        chk("rst_adr32", 64'(m32.MemAdr), 64'd0);
        chk("rst_wbe32", 64'(m32.WriteByteEn), 64'd0);
        chk("rst_lr32", 64'(lr32), 64'd0);
        chk("rst_stall32", 64'(st32), 64'd0);
        chk("rst_memen64", 64'(m64.MemEn), 64'd0);
        chk("rst_lr64", lr64, 64'd0);
        rst = 1'b0;

        d_ready = 1'b1; d_data = 32'hDEADBEEF;
        do_acc(2'b10, 3'b010, 32'h100, 32'h0, stalls, res, adr0, adr1);
        chk("lw_adr", 64'(adr0), 64'h100);
        chk("lw_data", 64'(res), 64'hDEADBEEF);
        chk("lw_stalls", 64'(stalls), 64'd2);

        d_data = 32'h80123456;
        do_acc(2'b10, 3'b000, 32'h103, 32'h0, stalls, res, adr0, adr1);
        chk("lb_sext", 64'(res), 64'hFFFFFF80);
        do_acc(2'b10, 3'b100, 32'h103, 32'h0, stalls, res, adr0, adr1);
        chk("lbu_zext", 64'(res), 64'h80);

        step();
        rw32 = 2'b10; f32 = 3'b010; a32 = 32'h102; d_data = 32'h3344AABB;
        #1;
        chk("split_stall0", 64'(st32), 64'd1);
        step();
        chk("split_adr0", 64'(m32.MemAdr), 64'h100);
        step();
        chk("split_adr1", 64'(m32.MemAdr), 64'h104);
        d_data = 32'h77665511;
        step();
        chk("split_stall_done", 64'(st32), 64'd0);
        chk("split_lw", 64'(lr32), 64'h55113344);
        rw32 = 2'b00;

        step();
        rw32 = 2'b01; f32 = 3'b010; a32 = 32'h103; sd32 = 32'h11223344;
        #1;
        step();
        chk("sw_adr0", 64'(m32.MemAdr), 64'h100);
        chk("sw_we0", 64'(m32.WriteEn), 64'd1);
        chk("sw_wbe0", 64'(m32.WriteByteEn), 64'b1000);
        chk("sw_byte0", 64'(m32.MemWriteData[31:24]), 64'h44);
        step();
        chk("sw_adr1", 64'(m32.MemAdr), 64'h104);
        chk("sw_wbe1", 64'(m32.WriteByteEn), 64'b0111);
        chk("sw_bytes1", 64'(m32.MemWriteData[23:0]), 64'h112233);
        step();
        chk("sw_done_memen", 64'(m32.MemEn), 64'd0);
        chk("sw_done_wbe", 64'(m32.WriteByteEn), 64'd0);
        rw32 = 2'b00;

        step();
        rw32 = 2'b01; f32 = 3'b010; a32 = 32'h200; sd32 = 32'hA5A50001; d_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("wait_stall", 64'(st32), 64'd1);
            chk("wait_memen", 64'(m32.MemEn), 64'd1);
            chk("wait_adr", 64'(m32.MemAdr), 64'h200);
            chk("wait_wbe", 64'(m32.WriteByteEn), 64'hF);
        end
        step();
        chk("wait_memen4", 64'(m32.MemEn), 64'd1);
        d_ready = 1'b1;
        step();
        chk("wait_done_stall", 64'(st32), 64'd0);
        chk("wait_done_memen", 64'(m32.MemEn), 64'd0);
        rw32 = 2'b00;

        step();
        rw32 = 2'b01; f32 = 3'b010; a32 = 32'h102; sd32 = 32'hCAFEF00D;
        #1;
        step();
        step();
        chk("rstmid_beat1", 64'(m32.MemEn), 64'd1);
        rst = 1'b1;
        rw32 = 2'b00;
        step();
        chk("rstmid_memen", 64'(m32.MemEn), 64'd0);
        chk("rstmid_we", 64'(m32.WriteEn), 64'd0);
        chk("rstmid_adr", 64'(m32.MemAdr), 64'd0);
        chk("rstmid_wbe", 64'(m32.WriteByteEn), 64'd0);
        chk("rstmid_wdata", 64'(m32.MemWriteData), 64'd0);
        chk("rstmid_stall", 64'(st32), 64'd0);
        chk("rstmid_lr", 64'(lr32), 64'd0);
        rst = 1'b0;

        step();
        rw64 = 2'b10; f64 = 3'b001; a64 = 64'hFF;
        #1;
        chk("fault_pulse", 64'(ft64), 64'd1);
        chk("fault_stall", 64'(st64), 64'd0);
        step();
        rw64 = 2'b00;
        chk("fault_memen", 64'(m64.MemEn), 64'd0);
        #1;
        chk("fault_clear", 64'(ft64), 64'd0);
        step();
        chk("fault_memen2", 64'(m64.MemEn), 64'd0);

        acc64("ld", 3'b011, 64'h8, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF);
        acc64("lwu", 3'b110, 64'hC, 64'h0123456789ABCDEF, 64'h0000000001234567);
        acc64("lw64", 3'b010, 64'hC, 64'h8000000000000000, 64'hFFFFFFFF80000000);
        chk("misen1_nofault", 64'(ft32), 64'd0);

        auto = 1'b1;
        for (int n = 0; n < 200; n++) begin
            a  = $urandom_range(0, 60);
            sd = $urandom;
            if ($urandom_range(0, 1) != 0) begin
                rw = 2'b10;
                f3 = ld_ops[$urandom_range(0, 4)];
            end else begin
                rw = 2'b01;
                f3 = 3'($urandom_range(0, 2));
            end
            sz    = 1 << f3[1:0];
            split = (int'(a % 4) + sz) > 4;
            exp   = ref_load(f3, a);
            w0    = waits;
            do_acc(rw, f3, a, sd, stalls, res, adr0, adr1);
            chk("rnd_stalls", 64'(stalls), 64'(1 + (split ? 2 : 1) + (waits - w0)));
            chk("rnd_adr0", 64'(adr0), 64'(a & ~32'd3));
            chk("rnd_adr1", 64'(adr1), 64'(split ? (a & ~32'd3) + 32'd4 : (a & ~32'd3)));
            if (rw == 2'b10) chk("rnd_load", 64'(res), 64'(exp));
            else
                for (int i = 0; i < sz; i++) refm[8'(a + 32'(i))] = sd[8*i +: 8];
        end
        auto = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
